// File: rtl/lcd_text_scheduler_if.sv
// Byte-level handshake between the text scheduler and the LCD nibble controller.
// The scheduler is the master; the controller answers each strobe with one ack pulse.
interface lcd_text_scheduler_if;
  logic [7:0] lcd_data;
  logic       lcd_rs;
  logic       lcd_strobe;
  logic       lcd_ack;

  modport master (
    output lcd_data,
    output lcd_rs,
    output lcd_strobe,
    input  lcd_ack
  );

  modport slave (
    input  lcd_data,
    input  lcd_rs,
    input  lcd_strobe,
    output lcd_ack
  );
endinterface

// File: rtl/lcd_text_scheduler.sv
// Configures an HD44780 display after controller power-up, then streams a 2x16
// frame buffer to it as set-address commands followed by character writes.
module lcd_text_scheduler #(
  parameter int unsigned CLEAR_WAIT_CYCLES = 82000,
  parameter bit          AUTO_REFRESH      = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        buf_we,
  input  logic [4:0]                  buf_addr,
  input  logic [7:0]                  buf_data,
  input  logic                        refresh_req,
  input  logic                        lcd_init_done,
  lcd_text_scheduler_if.master        lcd,
  output logic                        busy,
  output logic                        refresh_done
);

  localparam logic [19:0] CLEAR_LAST = 20'(CLEAR_WAIT_CYCLES - 1);

  typedef enum logic [3:0] {
    S_WAIT_INIT,
    S_CFG_FUNC,
    S_CFG_ENTRY,
    S_CFG_DISP,
    S_CFG_CLEAR,
    S_WAIT_CLEAR,
    S_IDLE,
    S_SET_ADDR,
    S_WRITE_CHAR,
    S_WAIT_ACK
  } state_t;

  state_t      state;
  state_t      state_nxt;
  state_t      ret_state;

  logic [7:0]  frame [32];
  logic        dirty;
  logic        line;
  logic [3:0]  col;
  logic [19:0] wait_cnt;
  logic [7:0]  data_q;
  logic        rs_q;

  logic        is_send;
  logic [7:0]  send_byte;
  logic        send_rs;
  logic        start;
  logic        char_ack;
  logic        last_ack;

  // Every send state strobes for one cycle and parks in WAIT_ACK; ret_state remembers
  // which send state it came from so the ack can resume the right sequence.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_WAIT_INIT;
      ret_state <= S_WAIT_INIT;
    end else begin
      state <= state_nxt;
      if (is_send) begin
        ret_state <= state;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    is_send   = 1'b0;
    send_byte = 8'h00;
    send_rs   = 1'b0;
    start     = 1'b0;
    char_ack  = 1'b0;
    last_ack  = 1'b0;
    case (state)
      S_WAIT_INIT: begin
        if (lcd_init_done) state_nxt = S_CFG_FUNC;
      end
      S_CFG_FUNC: begin
        is_send   = 1'b1;
        send_byte = 8'h28;
        state_nxt = S_WAIT_ACK;
      end
      S_CFG_ENTRY: begin
        is_send   = 1'b1;
        send_byte = 8'h06;
        state_nxt = S_WAIT_ACK;
      end
      S_CFG_DISP: begin
        is_send   = 1'b1;
        send_byte = 8'h0C;
        state_nxt = S_WAIT_ACK;
      end
      S_CFG_CLEAR: begin
        is_send   = 1'b1;
        send_byte = 8'h01;
        state_nxt = S_WAIT_ACK;
      end
      S_WAIT_CLEAR: begin
        if (wait_cnt == CLEAR_LAST) state_nxt = S_IDLE;
      end
      S_IDLE: begin
        if (refresh_req || (AUTO_REFRESH && dirty)) begin
          start     = 1'b1;
          state_nxt = S_SET_ADDR;
        end
      end
      S_SET_ADDR: begin
        is_send   = 1'b1;
        send_byte = line ? 8'hC0 : 8'h80;
        state_nxt = S_WAIT_ACK;
      end
      S_WRITE_CHAR: begin
        is_send   = 1'b1;
        send_byte = frame[{line, col}];
        send_rs   = 1'b1;
        state_nxt = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (lcd.lcd_ack) begin
          case (ret_state)
            S_CFG_FUNC:  state_nxt = S_CFG_ENTRY;
            S_CFG_ENTRY: state_nxt = S_CFG_DISP;
            S_CFG_DISP:  state_nxt = S_CFG_CLEAR;
            S_CFG_CLEAR: state_nxt = S_WAIT_CLEAR;
            S_SET_ADDR:  state_nxt = S_WRITE_CHAR;
            S_WRITE_CHAR: begin
              char_ack = 1'b1;
              if (col != 4'd15) begin
                state_nxt = S_WRITE_CHAR;
              end else if (!line) begin
                state_nxt = S_SET_ADDR;
              end else begin
                last_ack  = 1'b1;
                state_nxt = S_IDLE;
              end
            end
            default: state_nxt = S_WAIT_INIT;
          endcase
        end
      end
      default: state_nxt = S_WAIT_INIT;
    endcase
  end

  // A buffer write always wins over the refresh start so that a character landing in
  // the same cycle as the start still forces one more pass.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) begin
        frame[i] <= 8'h20;
      end
      dirty        <= 1'b1;
      line         <= 1'b0;
      col          <= 4'd0;
      wait_cnt     <= 20'd0;
      data_q       <= 8'h00;
      rs_q         <= 1'b0;
      refresh_done <= 1'b0;
    end else begin
      refresh_done <= last_ack;
      wait_cnt     <= (state == S_WAIT_CLEAR) ? wait_cnt + 20'd1 : 20'd0;
      if (is_send) begin
        data_q <= send_byte;
        rs_q   <= send_rs;
      end
      if (start) begin
        line <= 1'b0;
        col  <= 4'd0;
      end else if (char_ack) begin
        if (col == 4'd15) begin
          line <= 1'b1;
          col  <= 4'd0;
        end else begin
          col <= col + 4'd1;
        end
      end
      if (buf_we) begin
        frame[buf_addr] <= buf_data;
        dirty           <= 1'b1;
      end else if (start) begin
        dirty <= 1'b0;
      end
    end
  end

  assign lcd.lcd_strobe = is_send;
  assign lcd.lcd_data   = is_send ? send_byte : data_q;
  assign lcd.lcd_rs     = is_send ? send_rs : rs_q;
  assign busy           = (state != S_IDLE);

endmodule
